// File: rtl/player_motion_ctrl_pkg.sv
// Shared definitions for the player motion block: screen/character geometry,
// motion state encodings, collision flag bit positions and key indices.
package player_motion_ctrl_pkg;

    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;
    localparam int CHAR_W = 23;
    localparam int CHAR_H = 45;

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_RISE   = 2'b01,
        ST_FALL   = 2'b10
    } motion_state_e;

    localparam int COL_DOWN  = 0;
    localparam int COL_UP    = 1;
    localparam int COL_RIGHT = 2;
    localparam int COL_LEFT  = 3;

    localparam int NUM_KEYS  = 3;
    localparam int KEY_LEFT  = 0;
    localparam int KEY_RIGHT = 1;
    localparam int KEY_JUMP  = 2;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Tick/key/collision inputs and position/state outputs of the motion block.
interface player_motion_ctrl_if;

    logic       tick;
    logic       key_left;
    logic       key_right;
    logic       key_jump;
    logic [3:0] is_Collision;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic [1:0] state;
    logic       on_ground;

    modport master (
        output tick, key_left, key_right, key_jump, is_Collision,
        input  x_pos, y_pos, state, on_ground
    );

    modport slave (
        input  tick, key_left, key_right, key_jump, is_Collision,
        output x_pos, y_pos, state, on_ground
    );

endinterface

// File: rtl/player_motion_ctrl_key_edge.sv
// Two-flop synchroniser for one raw key level, with an optional rising-edge
// pulse (one clk wide) on the synchronised level.
module key_edge #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic rise_o
);

    logic sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    assign level_o = sync2_q;

    if (EDGE_EN) begin : g_edge
        logic prev_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) prev_q <= 1'b0;
            else     prev_q <= sync2_q;
        end
        assign rise_o = sync2_q & ~prev_q;
    end else begin : g_no_edge
        assign rise_o = 1'b0;
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Per-tick walk/jump/fall stepping of the player character.
// Optional feature macro: PLAYER_DOUBLE_JUMP_EN (one extra airborne jump).
module player_motion_ctrl
    import player_motion_ctrl_pkg::*;
#(
    parameter logic [9:0] X_INIT      = 10'd100,
    parameter logic [8:0] Y_INIT      = 9'd300,
    parameter logic [5:0] JUMP_HEIGHT = 6'd40,
    parameter logic [9:0] X_MAX       = 10'(SCR_W - CHAR_W),
    parameter logic [8:0] Y_MAX       = 9'(SCR_H - CHAR_H)
) (
    input  logic               clk,
    input  logic               rst,
    player_motion_ctrl_if.slave bus
);

    logic [NUM_KEYS-1:0] key_raw, key_lvl, key_rise;

    assign key_raw[KEY_LEFT]  = bus.key_left;
    assign key_raw[KEY_RIGHT] = bus.key_right;
    assign key_raw[KEY_JUMP]  = bus.key_jump;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_edge #(.EDGE_EN(k == KEY_JUMP)) u_key_edge (
            .clk     (clk),
            .rst     (rst),
            .key_i   (key_raw[k]),
            .level_o (key_lvl[k]),
            .rise_o  (key_rise[k])
        );
    end

    // Only the jump key needs an edge; walking uses the held level.
    logic unused_rise;
    assign unused_rise = key_rise[KEY_LEFT] | key_rise[KEY_RIGHT];

    motion_state_e state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [5:0]    rise_cnt_q, rise_cnt_d;
    logic          jump_req_q, jump_req_d;
    logic          on_ground_q;
    logic [3:0]    col;
    logic          go_left, go_right, dj_take;

    assign col      = bus.is_Collision;
    assign go_left  =  key_lvl[KEY_LEFT] & ~key_lvl[KEY_RIGHT];
    assign go_right = ~key_lvl[KEY_LEFT] &  key_lvl[KEY_RIGHT];

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic dj_used_q, dj_used_d;
    assign dj_take = (state_q != ST_GROUND) & jump_req_q & ~col[COL_UP] & ~dj_used_q;
`else
    assign dj_take = 1'b0;
`endif

    // Horizontal motion is independent of the vertical state.
    always_comb begin
        x_d = x_q;
        if (go_left && !col[COL_LEFT] && x_q != 10'd0)
            x_d = x_q - 10'd1;
        else if (go_right && !col[COL_RIGHT] && x_q < X_MAX)
            x_d = x_q + 10'd1;
    end

    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        rise_cnt_d = rise_cnt_q;
        jump_req_d = jump_req_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
        dj_used_d  = dj_used_q;
`endif
        if (bus.tick) begin
`ifndef PLAYER_DOUBLE_JUMP_EN
            if (state_q != ST_GROUND) jump_req_d = 1'b0;
`endif
            if (dj_take) begin
                state_d    = ST_RISE;
                rise_cnt_d = 6'd0;
                jump_req_d = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
                dj_used_d  = 1'b1;
`endif
            end else begin
                case (state_q)
                    ST_GROUND: begin
                        if (jump_req_q) begin
                            jump_req_d = 1'b0;
                            if (!col[COL_UP]) begin
                                state_d    = ST_RISE;
                                rise_cnt_d = 6'd0;
                            end
                        end else if (!col[COL_DOWN] && y_q < Y_MAX) begin
                            state_d = ST_FALL;
                        end
                    end
                    ST_RISE: begin
                        if (col[COL_UP] || y_q == 9'd0) begin
                            state_d = ST_FALL;
                        end else begin
                            y_d        = y_q - 9'd1;
                            rise_cnt_d = rise_cnt_q + 6'd1;
                            if (rise_cnt_q == JUMP_HEIGHT - 6'd1) state_d = ST_FALL;
                        end
                    end
                    ST_FALL: begin
                        if (col[COL_DOWN] || y_q == Y_MAX) begin
                            state_d = ST_GROUND;
`ifdef PLAYER_DOUBLE_JUMP_EN
                            dj_used_d = 1'b0;
`endif
                        end else begin
                            y_d = y_q + 9'd1;
                        end
                    end
                    default: state_d = ST_FALL;
                endcase
            end
        end
        // A fresh press wins over a same-cycle clear.
        if (key_rise[KEY_JUMP]) jump_req_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FALL;
            on_ground_q <= 1'b0;
            x_q         <= X_INIT;
            y_q         <= Y_INIT;
            rise_cnt_q  <= 6'd0;
            jump_req_q  <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_used_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            on_ground_q <= (state_d == ST_GROUND);
            x_q         <= bus.tick ? x_d : x_q;
            y_q         <= y_d;
            rise_cnt_q  <= rise_cnt_d;
            jump_req_q  <= jump_req_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_used_q   <= dj_used_d;
`endif
        end
    end

    assign bus.x_pos     = x_q;
    assign bus.y_pos     = y_q;
    assign bus.state     = state_q;
    assign bus.on_ground = on_ground_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl: reset, fall, jump, head bump,
// horizontal limits, airborne jump handling and asynchronous reset.
module tb_player_motion_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    player_motion_ctrl_if bus();

    player_motion_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(negedge clk) bus.tick = 1'b1;
            @(negedge clk) bus.tick = 1'b0;
        end
    endtask

    task automatic pulse_jump();
        @(negedge clk) bus.key_jump = 1'b1;
        repeat (4) @(negedge clk);
        bus.key_jump = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic settle_keys();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.key_left = 1'b0;
        bus.key_right = 1'b0;
        bus.key_jump = 1'b0;
        bus.is_Collision = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_x", 32'(bus.x_pos), 100);
        check("rst_y", 32'(bus.y_pos), 300);
        check("rst_state", 32'(bus.state), 2);
        check("rst_on_ground", 32'(bus.on_ground), 0);
        rst = 1'b0;

        // Free fall from reset
        ticks(10);
        check("fall10_y", 32'(bus.y_pos), 310);
        check("fall10_x", 32'(bus.x_pos), 100);
        check("fall10_state", 32'(bus.state), 2);

        // Land on a ledge, then a full-height jump
        bus.is_Collision = 4'b0001;
        ticks(1);
        check("land_state", 32'(bus.state), 0);
        check("land_on_ground", 32'(bus.on_ground), 1);
        check("land_y", 32'(bus.y_pos), 310);
        pulse_jump();
        ticks(1);
        check("jump_state", 32'(bus.state), 1);
        check("jump_y", 32'(bus.y_pos), 310);
        bus.is_Collision = 4'b0000;
        ticks(39);
        check("rise39_y", 32'(bus.y_pos), 271);
        check("rise39_state", 32'(bus.state), 1);
        ticks(1);
        check("apex_y", 32'(bus.y_pos), 270);
        check("apex_state", 32'(bus.state), 2);
        ticks(165);
        check("floor_y", 32'(bus.y_pos), 435);
        check("floor_state_fall", 32'(bus.state), 2);
        ticks(1);
        check("floor_state", 32'(bus.state), 0);
        ticks(1);
        check("floor_hold_y", 32'(bus.y_pos), 435);
        check("floor_hold_state", 32'(bus.state), 0);

        // Head bump cuts the rise short
        pulse_jump();
        ticks(6);
        check("hb_rise_y", 32'(bus.y_pos), 430);
        check("hb_rise_state", 32'(bus.state), 1);
        bus.is_Collision = 4'b0010;
        ticks(1);
        check("hb_state", 32'(bus.state), 2);
        check("hb_y", 32'(bus.y_pos), 430);
        bus.is_Collision = 4'b0000;
        ticks(1);
        check("hb_fall_y", 32'(bus.y_pos), 431);
        ticks(5);
        check("hb_land_state", 32'(bus.state), 0);
        check("hb_land_y", 32'(bus.y_pos), 435);

        // Jump requested under a ceiling is dropped
        bus.is_Collision = 4'b0010;
        pulse_jump();
        ticks(1);
        check("ceil_state", 32'(bus.state), 0);
        bus.is_Collision = 4'b0000;
        ticks(1);
        check("ceil_drop_state", 32'(bus.state), 0);

        // Horizontal: blocked, free, right limit, both keys, left
        bus.key_right = 1'b1;
        bus.is_Collision = 4'b0100;
        settle_keys();
        ticks(5);
        check("right_blocked_x", 32'(bus.x_pos), 100);
        bus.is_Collision = 4'b0000;
        ticks(5);
        check("right_free_x", 32'(bus.x_pos), 105);
        ticks(512);
        check("right_limit_x", 32'(bus.x_pos), 617);
        ticks(3);
        check("right_clamp_x", 32'(bus.x_pos), 617);
        bus.key_left = 1'b1;
        settle_keys();
        ticks(4);
        check("both_keys_x", 32'(bus.x_pos), 617);
        bus.key_right = 1'b0;
        settle_keys();
        ticks(7);
        check("left_x", 32'(bus.x_pos), 610);
        bus.is_Collision = 4'b1000;
        ticks(2);
        check("left_blocked_x", 32'(bus.x_pos), 610);
        bus.is_Collision = 4'b0000;
        bus.key_left = 1'b0;
        settle_keys();

        // Airborne jump request
        pulse_jump();
        ticks(41);
        check("aj_apex_y", 32'(bus.y_pos), 395);
        ticks(2);
        pulse_jump();
        ticks(1);
`ifdef PLAYER_DOUBLE_JUMP_EN
        check("dj_state", 32'(bus.state), 1);
        check("dj_y", 32'(bus.y_pos), 397);
        ticks(3);
        pulse_jump();
        ticks(1);
        check("tj_state", 32'(bus.state), 1);
        check("tj_y", 32'(bus.y_pos), 393);
        ticks(36);
        check("dj_apex_y", 32'(bus.y_pos), 357);
        check("dj_apex_state", 32'(bus.state), 2);
        ticks(79);
        check("dj_land_state", 32'(bus.state), 0);
        ticks(1);
        check("tj_pending_state", 32'(bus.state), 1);
`else
        check("aj_state", 32'(bus.state), 2);
        check("aj_y", 32'(bus.y_pos), 398);
        ticks(38);
        check("aj_land_state", 32'(bus.state), 0);
        ticks(1);
        check("aj_dropped_state", 32'(bus.state), 0);
        pulse_jump();
        ticks(1);
`endif
        ticks(2);
        check("pre_rst_y", 32'(bus.y_pos), 433);
        check("pre_rst_state", 32'(bus.state), 1);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_x", 32'(bus.x_pos), 100);
        check("arst_y", 32'(bus.y_pos), 300);
        check("arst_state", 32'(bus.state), 2);
        check("arst_on_ground", 32'(bus.on_ground), 0);
        @(negedge clk) rst = 1'b0;

        // Left limit at 0 while falling
        bus.key_left = 1'b1;
        settle_keys();
        ticks(103);
        check("left_limit_x", 32'(bus.x_pos), 0);
        check("left_limit_y", 32'(bus.y_pos), 403);
        bus.key_left = 1'b0;

        // Walk off a ledge
        bus.is_Collision = 4'b0001;
        ticks(1);
        check("ledge_land_state", 32'(bus.state), 0);
        bus.is_Collision = 4'b0000;
        ticks(1);
        check("ledge_off_state", 32'(bus.state), 2);
        check("ledge_off_y", 32'(bus.y_pos), 403);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
